reg8file_ctrl: RTL
==================

Name: reg8file_ctrl

Overview:
Command sequencer for the 8x8 register file. It accepts one command at a time over a valid/ready interface (WRITE, MOVE, READ, ADD) and drives the register file's write enable, write select, read select and write data. It returns READ and ADD results on a one-cycle response strobe. It is instantiated next to the register file at lab top level, with the file's q output fed back into rf_q.

Parameters:
DATA_W, 8, register width; must match the register file data width
ADDR_W, 3, register index width (2**ADDR_W registers)

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-high reset; same net as the register file's clr
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command (high only in IDLE)
cmd_op  in  2  00 WRITE, 01 MOVE, 10 READ, 11 ADD
cmd_rd  in  ADDR_W  destination register index
cmd_rs  in  ADDR_W  source register index
cmd_imm  in  DATA_W  immediate value for WRITE
rsp_valid  out  1  one-cycle pulse: rsp_data and rsp_carry are valid
rsp_data  out  DATA_W  READ value or ADD sum
rsp_carry  out  1  ADD carry-out; 0 for READ
busy  out  1  equals ~cmd_ready
rf_en  out  1  register file write enable
rf_wsel  out  ADDR_W  register file write select
rf_rsel  out  ADDR_W  register file read select
rf_d  out  DATA_W  register file write data
rf_q  in  DATA_W  register file combinational read data

Behaviour:
- Reset (clr=1, asynchronous):
  - state=IDLE.
  - Registered op, rd, rs, imm, tmp, rsp_data, rsp_carry and rsp_valid all cleared to 0.
  - Outputs: cmd_ready=1, rf_en=0, rf_wsel/rf_rsel/rf_d=0.
  - Register file contents are also zeroed via the shared clr.
  - A clr mid-command aborts it; no partial write occurs after clr deasserts.
- Accept: on a rising edge with cmd_valid & cmd_ready, latch op/rd/rs/imm and go to EXEC.
  - While not IDLE, cmd_ready=0; the requester must hold its command.
- States: IDLE, EXEC, ADD2. rf_* outputs are decoded combinationally from state and the latched fields.
  - IDLE: rf_en=0. Next state is EXEC on accept, otherwise IDLE.
  - EXEC, WRITE: rf_en=1, rf_wsel=rd, rf_d=imm. Next state IDLE.
  - EXEC, MOVE: rf_rsel=rs, rf_wsel=rd, rf_d=rf_q, rf_en=1. Next state IDLE.
  - EXEC, READ: rf_rsel=rs, rf_en=0. Capture rf_q into rsp_data, set rsp_carry=0 and rsp_valid=1. Next state IDLE.
  - EXEC, ADD: rf_rsel=rs, rf_en=0. Capture rf_q into tmp. Next state ADD2.
  - ADD2: rf_rsel=rd, {carry,sum} = tmp + rf_q computed at DATA_W+1 bits. Drive rf_en=1, rf_wsel=rd, rf_d=sum[DATA_W-1:0]. Capture sum into rsp_data and carry into rsp_carry, set rsp_valid=1. Next state IDLE.
- Latency, with the command accepted at edge N:
  - WRITE/MOVE: write lands at edge N+1.
  - READ: rsp_valid is high in the cycle after N+1.
  - ADD: write lands at edge N+2; rsp_valid is high in the cycle after N+2.
- Throughput: one WRITE/MOVE/READ per 2 cycles; one ADD per 3 cycles.
- rsp_valid is a single-cycle pulse and is cleared the following edge. rsp_data and rsp_carry hold their value until the next response.
- Boundaries:
  - MOVE with rd==rs rewrites the same value.
  - ADD with rd==rs doubles the register.
  - ADD wraps modulo 2**DATA_W; the carry reports the overflow.
  - All 4 op encodings are legal; there is no error path.
  - cmd_valid while busy has no effect.
- Outside a write state, rf_wsel and rf_d are 0 and rf_en is never high.

Decomposition:
- Package reg8file_pkg holds:
  - op encodings OP_WRITE, OP_MOVE, OP_READ, OP_ADD;
  - state enum IDLE, EXEC, ADD2;
  - DATA_W/ADDR_W default constants.
- No sub-module: the controller is a single FSM plus datapath registers.
- The testbench instantiates reg8file_ctrl and reg8file together with clr shared between them.

Test Plan:
- Reset then WRITE r3=0x5A; READ r3 -> rsp_valid pulses once, rsp_data=0x5A, rsp_carry=0; cmd_ready is low exactly 1 cycle per command.
- WRITE r1=0x0F; MOVE r6<-r1; READ r6 -> 0x0F; READ r1 -> 0x0F (source unchanged).
- WRITE r2=0xF0, r4=0x20; ADD r4=r4+r2 -> rsp_data=0x10, rsp_carry=1, r4 reads back 0x10; cmd_ready is low 2 cycles for the ADD.
- WRITE r5=0x41; ADD r5=r5+r5 -> 0x82, carry=0; MOVE r0<-r0 leaves r0 unchanged.
- Hold cmd_valid with WRITE r7=0xAA across a busy ADD -> the WRITE is accepted only in the IDLE cycle, exactly once, and r7=0xAA.
- Assert clr in ADD2 for a half cycle -> state is IDLE immediately, rf_en=0, no rsp_valid, all registers read back 0x00.

Source files
------------

// File: rtl/reg8file_pkg.sv
// Shared definitions for the register-file command sequencer:
// command opcodes, controller states and default widths.
package reg8file_pkg;

  localparam int RF_DATA_W = 8;
  localparam int RF_ADDR_W = 3;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_MOVE  = 2'b01,
    OP_READ  = 2'b10,
    OP_ADD   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    ADD2 = 2'b10
  } state_t;

endpackage

// File: rtl/reg8file.sv
// 2**ADDR_W x DATA_W register file: one synchronous write port,
// one combinational read port, asynchronous clear of every entry.
module reg8file
  import reg8file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [ADDR_W-1:0] wsel,
  input  logic [ADDR_W-1:0] rsel,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (en) begin
      mem[wsel] <= d;
    end
  end

  assign q = mem[rsel];

endmodule

// File: rtl/reg8file_ctrl.sv
// Command sequencer for the register file: accepts WRITE/MOVE/READ/ADD
// over valid/ready, drives the file's ports and returns READ/ADD results.
module reg8file_ctrl
  import reg8file_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic              busy,
  output logic              rf_en,
  output logic [ADDR_W-1:0] rf_wsel,
  output logic [ADDR_W-1:0] rf_rsel,
  output logic [DATA_W-1:0] rf_d,
  input  logic [DATA_W-1:0] rf_q
);

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only in IDLE, so the
  // requester holds its command until then.

  state_t            state;
  state_t            state_next;
  op_t               op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [ADDR_W-1:0] rs_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] tmp_q;
  logic [DATA_W:0]   sum;
  logic              accept;

  assign accept = cmd_valid && (state == IDLE);
  assign sum    = {1'b0, tmp_q} + {1'b0, rf_q};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = accept ? EXEC : IDLE;
      EXEC:    state_next = (op_q == OP_ADD) ? ADD2 : IDLE;
      ADD2:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Register-file port decode; everything is zero unless a state needs it.
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    rf_en     = 1'b0;
    rf_wsel   = '0;
    rf_rsel   = '0;
    rf_d      = '0;
    case (state)
      EXEC: begin
        case (op_q)
          OP_WRITE: begin
            rf_en   = 1'b1;
            rf_wsel = rd_q;
            rf_d    = imm_q;
          end
          OP_MOVE: begin
            rf_en   = 1'b1;
            rf_rsel = rs_q;
            rf_wsel = rd_q;
            rf_d    = rf_q;
          end
          OP_READ: rf_rsel = rs_q;
          OP_ADD:  rf_rsel = rs_q;
          default: rf_en   = 1'b0;
        endcase
      end
      ADD2: begin
        rf_en   = 1'b1;
        rf_rsel = rd_q;
        rf_wsel = rd_q;
        rf_d    = sum[DATA_W-1:0];
      end
      default: rf_en = 1'b0;
    endcase
  end

  // Latched command fields, ADD operand and response registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      op_q      <= OP_WRITE;
      rd_q      <= '0;
      rs_q      <= '0;
      imm_q     <= '0;
      tmp_q     <= '0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        op_q  <= op_t'(cmd_op);
        rd_q  <= cmd_rd;
        rs_q  <= cmd_rs;
        imm_q <= cmd_imm;
      end
      if (state == EXEC && op_q == OP_READ) begin
        rsp_data  <= rf_q;
        rsp_carry <= 1'b0;
        rsp_valid <= 1'b1;
      end
      if (state == EXEC && op_q == OP_ADD) begin
        tmp_q <= rf_q;
      end
      if (state == ADD2) begin
        rsp_data  <= sum[DATA_W-1:0];
        rsp_carry <= sum[DATA_W];
        rsp_valid <= 1'b1;
      end
    end
  end

endmodule
